// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit
//   Iterative multiply/divide unit with architectural HI/LO registers.
//   Runs MULT/MULTU (shift-add) and DIV/DIVU (restoring shift-subtract)
//   over WIDTH cycles under a start/busy/done handshake, and services
//   MTHI/MTLO writes while idle. HI/LO are exposed continuously for MFHI/MFLO.
//
// Configuration macro:
//   MULDIV_DIV_EN  defined   -> divider datapath compiled in.
//                  undefined -> DIV/DIVU complete in one cycle with err=1,
//                               HI/LO untouched.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   start           request an operation (sampled only in IDLE)
//   op              00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   a, b            operands, captured at accept
//   hi_we, lo_we    MTHI/MTLO strobes (honoured only in IDLE)
//   wdata           MTHI/MTLO data
//   busy            operation in progress
//   done            one-cycle completion pulse
//   err             divide-by-zero / unsupported op, valid from done to next accept
//   hi, lo          HI/LO architectural registers
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits / quotient bits}.
  logic [2*WIDTH-1:0] acc_q, acc_step;
  logic [WIDTH-1:0]   b_q;
  logic               is_div_q;
  logic               neg_res_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q, err_q;

  // Operand conditioning: magnitudes for signed ops, raw values otherwise.
  logic             is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, a_load;
  logic             neg_res_d;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & a[WIDTH-1];
  assign b_neg     = is_signed & b[WIDTH-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // Multiply step: conditionally add the multiplicand into the upper half,
  // then shift the whole accumulator right; the carry lands in the top bit.
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);

`ifdef MULDIV_DIV_EN
  logic           neg_rem_q, div_zero_q;
  logic           b_zero, div_zero_d;
  logic [WIDTH:0] rem_sh, rem_diff;
  logic           q_bit;

  assign b_zero     = (b == '0);
  assign div_zero_d = op[1] & b_zero;
  // A zero divisor runs the raw dividend through the divider unsigned: the
  // subtract never fails, so the quotient fills with ones and the remainder
  // ends equal to a, which is exactly the required result.
  assign a_load     = div_zero_d ? a : a_mag;
  assign neg_res_d  = ~div_zero_d & (a_neg ^ b_neg);

  // Restoring divide step: shift the next dividend bit into the remainder
  // and keep the difference only if it did not go negative.
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, b_q};
  assign q_bit    = ~rem_diff[WIDTH];

  always_comb begin
    if (!is_div_q)
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    else if (q_bit)
      acc_step = {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    else
      acc_step = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
  end
`else
  assign a_load    = a_mag;
  assign neg_res_d = a_neg ^ b_neg;
  assign acc_step  = {mul_sum, acc_q[WIDTH-1:1]};
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first so no path through
  // the case can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef MULDIV_DIV_EN
          state_d = S_RUN;
`else
          state_d = op[1] ? S_FIX : S_RUN;
`endif
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        busy    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      b_q        <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef MULDIV_DIV_EN
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A same-cycle start still honours the write; FIX overwrites it later.
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            cnt_q      <= '0;
            acc_q      <= {{WIDTH{1'b0}}, a_load};
            b_q        <= b_mag;
            is_div_q   <= op[1];
            neg_res_q  <= neg_res_d;
            err_q      <= 1'b0;
`ifdef MULDIV_DIV_EN
            neg_rem_q  <= a_neg & ~div_zero_d;
            div_zero_q <= div_zero_d;
`endif
          end
        end
        S_RUN: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 1'b1;
        end
        S_FIX: begin
          done_q <= 1'b1;
          if (!is_div_q) begin
            {hi_q, lo_q} <= neg_res_q ? -acc_q : acc_q;
            err_q        <= 1'b0;
          end else begin
`ifdef MULDIV_DIV_EN
            lo_q  <= neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
            hi_q  <= neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            err_q <= div_zero_q;
`else
            err_q <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign done = done_q;
  assign err  = err_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mips_muldiv_unit.md
# mips_muldiv_unit

Parametrised iterative multiply/divide unit with architectural HI/LO registers. It sits beside the single-cycle ALU in the MIPS datapath and executes MULT/MULTU/DIV/DIVU over multiple cycles under a start/busy/done handshake. It also services MTHI/MTLO writes and exposes HI/LO continuously for MFHI/MFLO. Generalised to any operand width.

## Interface
- WIDTH, 32, operand and HI/LO width (≥4)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request operation; sampled only in IDLE
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- a  in  WIDTH  multiplicand / dividend, captured at accept
- b  in  WIDTH  multiplier / divisor, captured at accept
- hi_we  in  1  MTHI: write wdata to HI
- lo_we  in  1  MTLO: write wdata to LO
- wdata  in  WIDTH  HI/LO write data
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- err  out  1  divide-by-zero, or unsupported op; valid from done until next accept
- hi  out  WIDTH  HI register (product upper half / remainder)
- lo  out  WIDTH  LO register (product lower half / quotient)

## Operation
- States: IDLE, RUN, FIX.
- IDLE: start=1 at an edge → capture op, |a|, |b| (magnitudes for signed ops, raw values for unsigned), result signs, and a zero-divisor flag; counter=0; busy=1; → RUN.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; counter increments; after WIDTH steps → FIX.
- FIX: apply sign correction; write HI/LO; done=1; busy=0; → IDLE.
- Multiply: 2·WIDTH-bit product; HI = upper WIDTH bits, LO = lower WIDTH bits. Signed: product negated when sign(a)≠sign(b).
- Divide: LO = quotient, HI = remainder. Signed: quotient negated when sign(a)≠sign(b); remainder takes sign(a). Most-negative ÷ −1 yields LO = most-negative, HI = 0.
- Divide by zero (b==0, DIV or DIVU): full latency; HI = a (unmodified), LO = all ones; err=1.
- start in RUN or FIX: ignored. There is no queueing.
- hi_we/lo_we in IDLE: the register is updated at that edge. hi_we/lo_we in RUN or FIX: dropped.
- start and hi_we/lo_we in the same IDLE cycle: the write is applied, and the operation result later overwrites it.
- err is cleared at each accept and updated at FIX.
- HI/LO are unchanged during RUN; intermediate state is internal only.

## Timing
- Accept at edge 0. RUN steps at edges 1..WIDTH. FIX at edge WIDTH+1.
- busy is high after edge 0 and low after edge WIDTH+1.
- done is high after edge WIDTH+1 and low after edge WIDTH+2.
- HI/LO valid after edge WIDTH+1, i.e. 33 cycles for WIDTH=32.
- start may be asserted in the done cycle (state is IDLE) and is accepted. This gives back-to-back throughput of one operation per WIDTH+2 cycles.
- Reset (async, any time, including mid-operation): state=IDLE; busy=0, done=0, err=0, hi=0, lo=0; counter and internal registers cleared. An aborted operation produces no done.

## Configuration
- MULDIV_DIV_EN defined: divider datapath compiled in; all four ops behave as above.
- MULDIV_DIV_EN undefined: divider logic omitted. An accepted DIV/DIVU goes directly to FIX: done pulses after edge 1, HI/LO unchanged, err=1. MULT/MULTU are unaffected.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=5 → after 33 cycles: done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFF1, err=0; busy high for exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). DIVU a=100, b=7 → lo=14, hi=2.
- DIVU a=100, b=0 → hi=100, lo=0xFFFFFFFF, err=1; the next MULT clears err at accept.
- Second start at cycle 5 of a running MULT: ignored, and only one done pulse occurs. Start in the done cycle: accepted, and busy is reasserted next cycle.
- Idle hi_we with wdata=0x1234 → hi=0x1234 next edge. hi_we during RUN: dropped. rst asserted at cycle 10 of a DIV: hi=lo=0, busy=0, and no done follows.
- With MULDIV_DIV_EN undefined: DIV → done after edge 1, err=1, HI/LO unchanged.
